// File: rtl/sort_4x8b_byte_packer.sv
// Byte-stream to LANES-wide word packer with a registered, backpressured output slot.
// Optional SORT_PACK_STATS_EN adds saturating output-handshake counters.
module sort_4x8b_byte_packer #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       LANES   = 4,
  parameter logic [DATA_W-1:0] PAD_VAL = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W*LANES-1:0]  out_data,
  output logic [2:0]               out_lanes
`ifdef SORT_PACK_STATS_EN
  ,
  output logic [15:0]              stat_words,
  output logic [15:0]              stat_partial
`endif
);

  localparam int unsigned FILL_W = (LANES > 2) ? $clog2(LANES) : 1;

  typedef logic [FILL_W-1:0]              fill_t;
  typedef logic [LANES-1:0][DATA_W-1:0]   word_t;

  fill_t fill;
  word_t asm_q;
  word_t asm_next;
  word_t word_done;
  logic  accept;
  logic  complete;

  always_comb begin
    in_ready  = !out_valid || out_ready;
    accept    = in_valid && in_ready;
    complete  = accept && (in_last || (fill == fill_t'(LANES - 1)));
    asm_next  = asm_q;
    word_done = asm_q;
    // asm_next keeps unfilled lanes at 0; word_done pads them for a flush
    for (int unsigned i = 0; i < LANES; i++) begin
      if (fill_t'(i) == fill) begin
        asm_next[i]  = in_data;
        word_done[i] = in_data;
      end else if (fill_t'(i) > fill) begin
        word_done[i] = PAD_VAL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill      <= '0;
      asm_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lanes <= '0;
    end else begin
      if (accept) begin
        if (complete) begin
          fill  <= '0;
          asm_q <= '0;
        end else begin
          fill  <= fill + fill_t'(1);
          asm_q <= asm_next;
        end
      end
      // A completing word reloads the slot even while the old one drains
      if (complete) begin
        out_data  <= word_done;
        out_lanes <= 3'(fill) + 3'd1;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SORT_PACK_STATS_EN
  logic handshake;
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words   <= '0;
      stat_partial <= '0;
    end else if (handshake) begin
      if (stat_words != '1) begin
        stat_words <= stat_words + 16'd1;
      end
      if ((32'(out_lanes) < LANES) && (stat_partial != '1)) begin
        stat_partial <= stat_partial + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sort_4x8b_byte_packer.sv
// Directed self-checking bench for sort_4x8b_byte_packer (default LANES=4, PAD 8'hFF).
`timescale 1ns/1ps
module tb_sort_4x8b_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_lanes;
`ifdef SORT_PACK_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_partial;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  sort_4x8b_byte_packer #(.DATA_W(8), .LANES(4), .PAD_VAL(8'hFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lanes (out_lanes)
`ifdef SORT_PACK_STATS_EN
    ,
    .stat_words   (stat_words),
    .stat_partial (stat_partial)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #5ms;
    if (!done) begin
      n_fail++;
      $error("FAIL timeout: stimulus did not complete within the wait limit");
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_lanes", 32'(out_lanes), 32'(3'd0));
    chk("rst_in_ready", 32'(in_ready), 32'(1'b1));
    rst_n = 1'b1;
    tick();

    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("midrst_out_data", out_data, 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'(1'b1));
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_no_out", 32'(out_valid), 32'(1'b0));
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("postrst_3bytes_no_out", 32'(out_valid), 32'(1'b0));
    send(8'h44, 1'b0);
    chk("postrst_valid", 32'(out_valid), 32'(1'b1));
    chk("postrst_data", out_data, 32'h44332211);
    chk("postrst_lanes", 32'(out_lanes), 32'(3'd4));

    send(8'h12, 1'b0);
    chk("full_drain", 32'(out_valid), 32'(1'b0));
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    chk("full_3bytes_no_out", 32'(out_valid), 32'(1'b0));
    send(8'h78, 1'b0);
    chk("full_valid", 32'(out_valid), 32'(1'b1));
    chk("full_data", out_data, 32'h78563412);
    chk("full_lanes", 32'(out_lanes), 32'(3'd4));
    tick();
    chk("full_fall", 32'(out_valid), 32'(1'b0));

    send(8'h0A, 1'b0);
    send(8'h0B, 1'b1);
    chk("part2_valid", 32'(out_valid), 32'(1'b1));
    chk("part2_data", out_data, 32'hFFFF0B0A);
    chk("part2_lanes", 32'(out_lanes), 32'(3'd2));
    tick();

    send(8'h5C, 1'b1);
    chk("part1_data", out_data, 32'hFFFFFF5C);
    chk("part1_lanes", 32'(out_lanes), 32'(3'd1));
    send(8'h22, 1'b1);
    chk("b2b_valid", 32'(out_valid), 32'(1'b1));
    chk("b2b_data", out_data, 32'hFFFFFF22);
    tick();
    chk("b2b_fall", 32'(out_valid), 32'(1'b0));

    send(8'h31, 1'b0);
    in_data = 8'hEE; in_last = 1'b1;
    tick(); tick();
    in_last = 1'b0;
    chk("idle_no_out", 32'(out_valid), 32'(1'b0));
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    send(8'h34, 1'b0);
    chk("idle_data", out_data, 32'h34333231);
    chk("idle_lanes", 32'(out_lanes), 32'(3'd4));
    tick();

    out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    in_valid = 1'b1; in_data = 8'h99;
    for (int unsigned i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'(1'b0));
      chk("bp_valid", 32'(out_valid), 32'(1'b1));
      chk("bp_data", out_data, 32'h04030201);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("bp_drain", 32'(out_valid), 32'(1'b0));
    send(8'h98, 1'b0);
    send(8'h97, 1'b0);
    send(8'h96, 1'b0);
    chk("bp_resume_data", out_data, 32'h96979899);
    chk("bp_resume_lanes", 32'(out_lanes), 32'(3'd4));
    tick();

`ifdef SORT_PACK_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("stat_rst_words", 32'(stat_words), 32'd0);
    chk("stat_rst_partial", 32'(stat_partial), 32'd0);
`endif

    for (int unsigned i = 0; i < 16; i++) begin
      chk("stream_in_ready", 32'(in_ready), 32'(1'b1));
      send(8'(i), 1'b0);
      if (i % 4 == 3) begin
        chk("stream_valid", 32'(out_valid), 32'(1'b1));
        chk("stream_data", out_data,
            {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
      end else if (i % 4 != 0 || i == 0) begin
        chk("stream_gap", 32'(out_valid), 32'(1'b0));
      end
    end
    tick();

`ifdef SORT_PACK_STATS_EN
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b1);
    tick();
    chk("stat_words5", 32'(stat_words), 32'd5);
    chk("stat_partial1", 32'(stat_partial), 32'd1);
    in_valid = 1'b1; in_last = 1'b1; in_data = 8'h42;
    for (int unsigned i = 0; i < 65536; i++) begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    chk("stat_words_sat", 32'(stat_words), 32'h0000FFFF);
    chk("stat_partial_sat", 32'(stat_partial), 32'h0000FFFF);
`endif

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
